// File: rtl/tl_ram_responder.sv
// rtl/tl_ram_responder.sv - TileLink-UH manager endpoint backed by a byte-maskable 64-bit word array
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   auto_in_a_*               A channel request (ready out; valid/opcode/param/size/source/address/mask/data/corrupt in)
//   auto_in_d_*               D channel response (ready in; valid/opcode/param/size/source/sink/denied/data/corrupt out)
// One transaction in flight; the A channel is closed while a response is being returned.
module tl_ram_responder #(
   parameter int          ADDR_BITS = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
   parameter int          MAX_SIZE  = 6
) (
   input  logic        clock,
   input  logic        reset,
   output logic        auto_in_a_ready,
   input  logic        auto_in_a_valid,
   input  logic [2:0]  auto_in_a_bits_opcode,
   input  logic [2:0]  auto_in_a_bits_param,
   input  logic [2:0]  auto_in_a_bits_size,
   input  logic [3:0]  auto_in_a_bits_source,
   input  logic [31:0] auto_in_a_bits_address,
   input  logic [7:0]  auto_in_a_bits_mask,
   input  logic [63:0] auto_in_a_bits_data,
   input  logic        auto_in_a_bits_corrupt,
   input  logic        auto_in_d_ready,
   output logic        auto_in_d_valid,
   output logic [2:0]  auto_in_d_bits_opcode,
   output logic [1:0]  auto_in_d_bits_param,
   output logic [2:0]  auto_in_d_bits_size,
   output logic [3:0]  auto_in_d_bits_source,
   output logic [1:0]  auto_in_d_bits_sink,
   output logic        auto_in_d_bits_denied,
   output logic [63:0] auto_in_d_bits_data,
   output logic        auto_in_d_bits_corrupt
);

   localparam int         IDX_W      = ADDR_BITS - 3;
   localparam int         WORDS      = 1 << IDX_W;
   localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

   localparam logic [2:0] OP_GET      = 3'd4;
   localparam logic [2:0] OP_HINT     = 3'd5;
   localparam logic [2:0] D_ACK       = 3'd0;
   localparam logic [2:0] D_ACK_DATA  = 3'd1;
   localparam logic [2:0] D_HINT_ACK  = 3'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_WACK,
      S_READ
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [4:0]       beat;
   logic [4:0]       beat_nxt;

   logic [2:0]       opcode_q;
   logic [2:0]       size_q;
   logic [3:0]       source_q;
   logic [IDX_W-1:0] base_q;
   logic             denied_q;

   logic [63:0]      mem [WORDS];

   logic             a_fire;
   logic             d_fire;
   logic             a_denied;
   logic             a_is_write;
   logic             atomic_q;
   logic [4:0]       beats_q;
   logic [4:0]       d_beats;
   logic             last_wbeat;
   logic             last_dbeat;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             unused_a;

   // Sub-word transfers still occupy one 64-bit beat.
   function automatic logic [4:0] beats_of(input logic [2:0] sz);
      if (sz <= 3'd3) begin
         return 5'd1;
      end
      return 5'd1 << (sz - 3'd3);
   endfunction

   assign unused_a = ^{auto_in_a_bits_param, auto_in_a_bits_address[2:0]};

   // Handshake enables depend only on state, so the fires below never loop back into them.
   assign auto_in_a_ready = !reset && (state == S_IDLE || state == S_WRITE);
   assign auto_in_d_valid = !reset && (state == S_WACK || state == S_READ);
   assign a_fire          = auto_in_a_ready && auto_in_a_valid;
   assign d_fire          = auto_in_d_valid && auto_in_d_ready;

   // Opcodes 2,3 (atomics, unsupported) and 6,7 (undefined) are refused.
   assign a_denied = (auto_in_a_bits_address[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS])
                   | (auto_in_a_bits_size > MAX_SIZE_L)
                   | (auto_in_a_bits_opcode inside {3'd2, 3'd3, 3'd6, 3'd7});
   assign a_is_write = (auto_in_a_bits_opcode <= 3'd3);

   assign atomic_q   = (opcode_q == 3'd2) || (opcode_q == 3'd3);
   assign beats_q    = beats_of(size_q);
   // Atomics answer with data beats matching the request size; all other acks are a single beat.
   assign d_beats    = (state == S_READ || atomic_q) ? beats_q : 5'd1;
   assign last_wbeat = (beat == beats_q - 5'd1);
   assign last_dbeat = (beat == d_beats - 5'd1);

   assign rd_idx = base_q + IDX_W'(beat);
   assign wr_idx = (state == S_IDLE) ? auto_in_a_bits_address[ADDR_BITS-1:3] : rd_idx;
   assign wr_en  = a_fire && !auto_in_a_bits_corrupt &&
                   (((state == S_IDLE) && a_is_write && !a_denied) ||
                    ((state == S_WRITE) && !denied_q));

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      case (state)
         S_IDLE: begin
            if (a_fire) begin
               beat_nxt = 5'd0;
               if (a_is_write) begin
                  if (beats_of(auto_in_a_bits_size) == 5'd1) begin
                     state_nxt = S_WACK;
                  end else begin
                     state_nxt = S_WRITE;
                     beat_nxt  = 5'd1;
                  end
               end else if (auto_in_a_bits_opcode == OP_GET) begin
                  state_nxt = S_READ;
               end else begin
                  state_nxt = S_WACK;
               end
            end
         end
         S_WRITE: begin
            if (a_fire) begin
               if (last_wbeat) begin
                  state_nxt = S_WACK;
                  beat_nxt  = 5'd0;
               end else begin
                  beat_nxt = beat + 5'd1;
               end
            end
         end
         S_WACK, S_READ: begin
            if (d_fire) begin
               if (last_dbeat) begin
                  state_nxt = S_IDLE;
                  beat_nxt  = 5'd0;
               end else begin
                  beat_nxt = beat + 5'd1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            beat_nxt  = 5'd0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         beat     <= 5'd0;
         opcode_q <= 3'd0;
         size_q   <= 3'd0;
         source_q <= 4'd0;
         base_q   <= '0;
         denied_q <= 1'b0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
         // Request fields are captured once; later beats of a burst cannot alter them.
         if (state == S_IDLE && a_fire) begin
            opcode_q <= auto_in_a_bits_opcode;
            size_q   <= auto_in_a_bits_size;
            source_q <= auto_in_a_bits_source;
            base_q   <= auto_in_a_bits_address[ADDR_BITS-1:3];
            denied_q <= a_denied;
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (auto_in_a_bits_mask[i]) begin
               mem[wr_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
            end
         end
      end
   end

   // D fields come only from latched state, so they hold steady across a stall.
   always_comb begin
      auto_in_d_bits_opcode  = D_ACK;
      auto_in_d_bits_data    = 64'd0;
      auto_in_d_bits_corrupt = 1'b0;
      if (state == S_READ) begin
         auto_in_d_bits_opcode  = D_ACK_DATA;
         auto_in_d_bits_data    = denied_q ? 64'd0 : mem[rd_idx];
         auto_in_d_bits_corrupt = denied_q;
      end else if (state == S_WACK) begin
         if (atomic_q) begin
            auto_in_d_bits_opcode  = D_ACK_DATA;
            auto_in_d_bits_corrupt = 1'b1;
         end else if (opcode_q == OP_HINT) begin
            auto_in_d_bits_opcode = D_HINT_ACK;
         end
      end
   end

   assign auto_in_d_bits_param  = 2'd0;
   assign auto_in_d_bits_sink   = 2'd0;
   assign auto_in_d_bits_size   = size_q;
   assign auto_in_d_bits_source = source_q;
   assign auto_in_d_bits_denied = denied_q;

endmodule
